// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: data width, default bit timing and the frame FSM
// state encoding used by both the receiver and the transmitter.
package uart_rx_pkg;

  localparam int DATA_BITS                = 8;
  localparam int DEFAULT_CLK_PER_HALF_BIT = 434;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } uart_state_t;

  // Width of a counter that must reach one full bit period minus one.
  function automatic int bit_cnt_width(input int half_bit);
    return $clog2(2 * half_bit);
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bundle: serial line in, byte holding register and status out.
// The master modport is the receiver, the slave modport is the line driver
// plus the byte consumer.
interface uart_rx_if;
  import uart_rx_pkg::*;

  logic                 rxd;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ack;
  logic                 ferr;
  logic                 overrun;

  modport master (
    input  rxd,
    input  rx_ack,
    output rx_data,
    output rx_valid,
    output ferr,
    output overrun
  );

  modport slave (
    output rxd,
    output rx_ack,
    input  rx_data,
    input  rx_valid,
    input  ferr,
    input  overrun
  );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line. Both stages reset
// to 1 so that a reset never looks like a start bit.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Two-stage capture of the pin into the clock domain, idle-high on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver. A start edge on the synchronised line opens a frame;
// the start bit is re-checked mid-bit, each data bit is sampled at its
// centre and shifted in LSB-first, and the stop bit decides between
// delivery into the valid/ack holding register and a framing-error pulse.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int CLK_PER_HALF_BIT = DEFAULT_CLK_PER_HALF_BIT
) (
  input logic       clk,
  input logic       rst,
  uart_rx_if.master bus
);

  localparam int CNT_W = bit_cnt_width(CLK_PER_HALF_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_PER_HALF_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(2 * CLK_PER_HALF_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

  logic                 w_rxd_s;
  uart_state_t          r_state;
  uart_state_t          w_state_next;
  logic [CNT_W-1:0]     r_cnt;
  logic [IDX_W-1:0]     r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_rx_valid;
  logic                 r_ferr;
  logic                 r_overrun;

  logic                 w_cnt_run;
  logic                 w_cnt_clr;
  logic                 w_shift_en;
  logic                 w_deliver;
  logic                 w_frame_err;

  uart_rx_sync u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (bus.rxd),
    .o_q (w_rxd_s)
  );

  // Frame state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode plus per-cycle strobes for counter, shifter and result.
  always_comb begin
    w_state_next = r_state;
    w_cnt_run    = 1'b0;
    w_cnt_clr    = 1'b0;
    w_shift_en   = 1'b0;
    w_deliver    = 1'b0;
    w_frame_err  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_rxd_s) begin
          w_state_next = ST_START;
          w_cnt_clr    = 1'b1;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_START: begin
        w_cnt_run = 1'b1;
        if (r_cnt == HALF_LAST) begin
          w_cnt_clr = 1'b1;
          // A line that is high again at mid-start-bit was only a glitch.
          if (!w_rxd_s) begin
            w_state_next = ST_DATA;
          end else begin
            w_state_next = ST_IDLE;
          end
        end else begin
          w_state_next = ST_START;
        end
      end
      ST_DATA: begin
        w_cnt_run = 1'b1;
        if (r_cnt == BIT_LAST) begin
          w_cnt_clr  = 1'b1;
          w_shift_en = 1'b1;
          if (r_bit_idx == IDX_LAST) begin
            w_state_next = ST_STOP;
          end else begin
            w_state_next = ST_DATA;
          end
        end else begin
          w_state_next = ST_DATA;
        end
      end
      ST_STOP: begin
        w_cnt_run = 1'b1;
        if (r_cnt == BIT_LAST) begin
          w_cnt_clr = 1'b1;
          // Returning straight to IDLE lets a back-to-back start edge be seen
          // on the very next cycle.
          if (w_rxd_s) begin
            w_deliver    = 1'b1;
            w_state_next = ST_IDLE;
          end else begin
            w_frame_err  = 1'b1;
            w_state_next = ST_WAIT_IDLE;
          end
        end else begin
          w_state_next = ST_STOP;
        end
      end
      ST_WAIT_IDLE: begin
        // A held-low line (break) must not be mistaken for a new start bit.
        if (w_rxd_s) begin
          w_state_next = ST_IDLE;
        end else begin
          w_state_next = ST_WAIT_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Bit-timing counter, data bit index and LSB-first shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= {CNT_W{1'b0}};
      r_bit_idx <= {IDX_W{1'b0}};
      r_shift   <= {DATA_BITS{1'b0}};
    end else begin
      if (w_cnt_clr || !w_cnt_run) begin
        r_cnt <= {CNT_W{1'b0}};
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end

      if (r_state == ST_IDLE) begin
        r_bit_idx <= {IDX_W{1'b0}};
      end else if (w_shift_en && (r_bit_idx != IDX_LAST)) begin
        r_bit_idx <= r_bit_idx + IDX_W'(1);
      end else begin
        r_bit_idx <= r_bit_idx;
      end

      if (w_shift_en) begin
        r_shift <= {w_rxd_s, r_shift[DATA_BITS-1:1]};
      end else begin
        r_shift <= r_shift;
      end
    end
  end

  // Holding register, valid/ack handshake, sticky overrun and ferr pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_data  <= {DATA_BITS{1'b0}};
      r_rx_valid <= 1'b0;
      r_overrun  <= 1'b0;
      r_ferr     <= 1'b0;
    end else begin
      r_ferr <= w_frame_err;

      // A consumer ack in the delivery cycle frees the slot for the new byte.
      if (w_deliver) begin
        if (!r_rx_valid || bus.rx_ack) begin
          r_rx_data  <= r_shift;
          r_rx_valid <= 1'b1;
        end else begin
          r_rx_data  <= r_rx_data;
          r_rx_valid <= r_rx_valid;
        end
      end else if (r_rx_valid && bus.rx_ack) begin
        r_rx_valid <= 1'b0;
      end else begin
        r_rx_valid <= r_rx_valid;
      end

      // Setting has priority over the ack-driven clear.
      if (w_deliver && r_rx_valid && !bus.rx_ack) begin
        r_overrun <= 1'b1;
      end else if (r_rx_valid && bus.rx_ack) begin
        r_overrun <= 1'b0;
      end else begin
        r_overrun <= r_overrun;
      end
    end
  end

  assign bus.rx_data  = r_rx_data;
  assign bus.rx_valid = r_rx_valid;
  assign bus.ferr     = r_ferr;
  assign bus.overrun  = r_overrun;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx with CLK_PER_HALF_BIT=4. Frames are driven
// on bit boundaries; a frame-level reference model predicts the cycle of each
// delivery or framing error and the resulting holding-register contents.
module tb_uart_rx;

  localparam int H   = 4;
  localparam int B   = 2 * H;
  localparam int LAT = 2 + 19 * H;  // first sampling edge -> result edge

  typedef struct {
    int         at;
    logic [7:0] d;
    logic       ok;
  } ev_t;

  logic clk;
  logic rst;

  uart_rx_if bus ();

  uart_rx #(.CLK_PER_HALF_BIT(H)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  ev_t        evq[$];
  int         ack_mode = 0;
  int         ack_at   = -1;
  int         last_start     = 0;
  int         valid_rise_cyc = -1;
  int         rise_cnt = 0;
  int         ferr_cnt = 0;
  logic [7:0] last_rx  = 8'h00;

  logic       exp_valid = 1'b0;
  logic [7:0] exp_data  = 8'h00;
  logic       exp_ovr   = 1'b0;
  logic       exp_ferr  = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference model: advance expected state at each edge, compare just after.
  initial begin : model
    ev_t  ev;
    logic dlv;
    logic ack_now;
    logic dut_valid_q;
    dut_valid_q = 1'b0;
    forever begin
      @(posedge clk);
      cyc     = cyc + 1;
      ack_now = bus.rx_ack;
      if (rst) begin
        exp_valid = 1'b0;
        exp_data  = 8'h00;
        exp_ovr   = 1'b0;
        exp_ferr  = 1'b0;
        evq.delete();
      end else begin
        dlv      = 1'b0;
        exp_ferr = 1'b0;
        if (evq.size() > 0 && evq[0].at == cyc) begin
          ev = evq.pop_front();
          if (ev.ok) dlv = 1'b1;
          else       exp_ferr = 1'b1;
        end
        if (dlv && exp_valid && !ack_now) exp_ovr = 1'b1;
        else if (exp_valid && ack_now)    exp_ovr = 1'b0;
        if (dlv) begin
          if (!exp_valid || ack_now) begin
            exp_data  = ev.d;
            exp_valid = 1'b1;
          end
        end else if (exp_valid && ack_now) begin
          exp_valid = 1'b0;
        end
      end
      #1;
      if (bus.rx_valid && !dut_valid_q) begin
        valid_rise_cyc = cyc;
        rise_cnt++;
        last_rx = bus.rx_data;
      end
      dut_valid_q = bus.rx_valid;
      if (bus.ferr) ferr_cnt++;
      check_eq("outs{valid,ferr,ovr,data}",
               32'({bus.rx_valid, bus.ferr, bus.overrun, bus.rx_data}),
               32'({exp_valid, exp_ferr, exp_ovr, exp_data}));
    end
  end

  // Consumer ack generator: off, auto-pulse, single scheduled cycle, random.
  initial begin : ack_drv
    bus.rx_ack = 1'b0;
    forever begin
      @(negedge clk);
      case (ack_mode)
        1:       bus.rx_ack = bus.rx_valid && !bus.rx_ack;
        2:       bus.rx_ack = ((cyc + 1) == ack_at);
        3:       bus.rx_ack = ($urandom_range(0, 63) == 0);
        default: bus.rx_ack = 1'b0;
      endcase
    end
  end

  task automatic idle(input int n);
    bus.rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Drive one frame starting at the current negedge; rst_bit>=0 aborts it
  // with a one-cycle reset in the middle of that data bit.
  task automatic send_frame(input logic [7:0] b, input logic stop_b, input int rst_bit);
    ev_t ev;
    bus.rxd    = 1'b0;
    last_start = cyc + 1;
    ev.at = last_start + LAT;
    ev.d  = b;
    ev.ok = stop_b;
    evq.push_back(ev);
    repeat (B) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.rxd = b[i];
      if (i == rst_bit) begin
        repeat (H) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst     = 1'b0;
        bus.rxd = 1'b1;
        return;
      end
      repeat (B) @(negedge clk);
    end
    bus.rxd = stop_b;
    repeat (B) @(negedge clk);
  endtask

  initial begin : main
    logic [7:0] rb;
    logic       rs;
    int         gap;
    int         base;
    rst     = 1'b1;
    bus.rxd = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_eq("reset_valid", 32'(bus.rx_valid), 32'd0);
    check_eq("reset_data",  32'(bus.rx_data),  32'h00);
    check_eq("reset_ferr",  32'(bus.ferr),     32'd0);
    check_eq("reset_ovr",   32'(bus.overrun),  32'd0);
    idle(5);

    // Single byte, no ack: exact latency from the pin edge.
    valid_rise_cyc = -1;
    send_frame(8'hA5, 1'b1, -1);
    idle(4);
    check_eq("a5_latency", 32'(valid_rise_cyc - last_start + 1), 32'(LAT + 1));
    check_eq("a5_data",    32'(bus.rx_data),  32'hA5);
    check_eq("a5_valid",   32'(bus.rx_valid), 32'd1);
    check_eq("a5_ferr",    32'(ferr_cnt),     32'd0);
    check_eq("a5_ovr",     32'(bus.overrun),  32'd0);
    ack_mode = 2;
    ack_at   = cyc + 2;
    idle(4);
    check_eq("a5_acked", 32'(bus.rx_valid), 32'd0);

    // Short low glitch must be rejected, then a real byte received.
    ack_mode = 1;
    base     = rise_cnt;
    bus.rxd  = 1'b0;
    repeat (2) @(negedge clk);
    idle(30);
    check_eq("glitch_no_valid", 32'(rise_cnt - base), 32'd0);
    check_eq("glitch_no_ferr",  32'(ferr_cnt),        32'd0);
    send_frame(8'h3C, 1'b1, -1);
    idle(10);
    check_eq("glitch_next", 32'(last_rx), 32'h3C);

    // Framing error followed by a held-low break.
    base = rise_cnt;
    send_frame(8'hFF, 1'b0, -1);
    repeat (40) @(negedge clk);
    check_eq("ferr_once",     32'(ferr_cnt),        32'd1);
    check_eq("ferr_no_valid", 32'(rise_cnt - base), 32'd0);
    idle(20);
    send_frame(8'h12, 1'b1, -1);
    idle(10);
    check_eq("ferr_next", 32'(last_rx), 32'h12);

    // Back-to-back frames with auto ack.
    base = rise_cnt;
    send_frame(8'h01, 1'b1, -1);
    send_frame(8'h80, 1'b1, -1);
    send_frame(8'h55, 1'b1, -1);
    idle(10);
    check_eq("b2b_count", 32'(rise_cnt - base), 32'd3);
    check_eq("b2b_last",  32'(last_rx),         32'h55);
    check_eq("b2b_ovr",   32'(bus.overrun),     32'd0);

    // Overrun: second byte dropped, ack clears both flags.
    ack_mode = 0;
    send_frame(8'h11, 1'b1, -1);
    send_frame(8'h22, 1'b1, -1);
    idle(4);
    check_eq("ovr_data",  32'(bus.rx_data),  32'h11);
    check_eq("ovr_flag",  32'(bus.overrun),  32'd1);
    check_eq("ovr_valid", 32'(bus.rx_valid), 32'd1);
    ack_mode = 2;
    ack_at   = cyc + 2;
    idle(4);
    check_eq("ovr_clr_valid", 32'(bus.rx_valid), 32'd0);
    check_eq("ovr_clr_flag",  32'(bus.overrun),  32'd0);

    // Ack coinciding with the second delivery replaces the byte.
    send_frame(8'h11, 1'b1, -1);
    ack_at = cyc + 1 + LAT;
    send_frame(8'h22, 1'b1, -1);
    idle(4);
    check_eq("same_ack_data",  32'(bus.rx_data),  32'h22);
    check_eq("same_ack_valid", 32'(bus.rx_valid), 32'd1);
    check_eq("same_ack_ovr",   32'(bus.overrun),  32'd0);
    ack_at = cyc + 2;
    idle(4);

    // Reset in the middle of a frame, with a byte already held.
    ack_mode = 0;
    send_frame(8'h77, 1'b1, -1);
    idle(4);
    check_eq("pre_rst_valid", 32'(bus.rx_valid), 32'd1);
    send_frame(8'hC3, 1'b1, 4);
    check_eq("rst_mid_valid", 32'(bus.rx_valid), 32'd0);
    check_eq("rst_mid_data",  32'(bus.rx_data),  32'h00);
    check_eq("rst_mid_ovr",   32'(bus.overrun),  32'd0);
    check_eq("rst_mid_ferr",  32'(bus.ferr),     32'd0);
    idle(100);
    ack_mode = 1;
    send_frame(8'h5A, 1'b1, -1);
    idle(10);
    check_eq("rst_next", 32'(last_rx), 32'h5A);

    // Randomised frames, stop bits, gaps and ack timing.
    ack_mode = 3;
    for (int k = 0; k < 30; k++) begin
      rb  = 8'($urandom);
      rs  = ($urandom_range(0, 7) != 0);
      gap = rs ? int'($urandom_range(0, 12)) : int'($urandom_range(2, 12));
      send_frame(rb, rs, -1);
      idle(gap);
    end
    idle(100);
    check_eq("events_drained", 32'(evq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
